controlador_cofre: RTL and testbench

- Sequencing controller for the keypad lock datapath: takes BCD digits strobed by `insere` and checks them against a stored N-digit password.
- Opens the lock (LED) on a full match. Counts failed attempts and enforces a timed lockout.
- Allows the password to be reprogrammed while open.
- Drives the 7-segment display (A..G) with the last accepted digit or a lockout dash.

---
 rtl/cofre_pkg.sv | 19 +
 rtl/decodificador_7seg.sv | 33 +++
 rtl/controlador_cofre.sv | 191 +++++++++++++++++++
 tb/tb_controlador_cofre.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cofre_pkg.sv
// Shared types and constants for the keypad lock controller.
package cofre_pkg;

  localparam int unsigned DIGITO_W = 4;
  localparam int unsigned SEG_W    = 7;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    ENTRADA   = 3'd1,
    ABERTO    = 3'd2,
    PROGRAMA  = 3'd3,
    BLOQUEADO = 3'd4
  } estado_t;

  // Segment vectors ordered {A,B,C,D,E,F,G}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;

endpackage

// File: rtl/decodificador_7seg.sv
// BCD to 7-segment decoder (active-high, {A..G}) with blank and dash overrides.
module decodificador_7seg
  import cofre_pkg::*;
(
  input  logic [DIGITO_W-1:0] digito,
  input  logic                apaga,
  input  logic                traco,
  output logic [SEG_W-1:0]    seg_c
);

  // Dash wins over blank; non-BCD codes decode to blank
  always_comb begin
    seg_c = SEG_BLANK;
    if (traco) begin
      seg_c = SEG_DASH;
    end else if (!apaga) begin
      case (digito)
        4'd0:    seg_c = 7'b1111110;
        4'd1:    seg_c = 7'b0110000;
        4'd2:    seg_c = 7'b1101101;
        4'd3:    seg_c = 7'b1111001;
        4'd4:    seg_c = 7'b0110011;
        4'd5:    seg_c = 7'b1011011;
        4'd6:    seg_c = 7'b1011111;
        4'd7:    seg_c = 7'b1110000;
        4'd8:    seg_c = 7'b1111111;
        4'd9:    seg_c = 7'b1111011;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/controlador_cofre.sv
// Keypad lock controller: password check, attempt counting, timed lockout,
// password reprogramming and 7-segment display of the last digit.
module controlador_cofre
  import cofre_pkg::*;
#(
  parameter int unsigned N_DIGITOS       = 6,
  parameter int unsigned MAX_TENTATIVAS  = 3,
  parameter int unsigned CICLOS_BLOQUEIO = 100,
  parameter logic [4*N_DIGITOS-1:0] SENHA_PADRAO = 24'h590281
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere,
  input  logic [4:1] numero,
  input  logic       modo,
  output logic       LED,
  output logic       bloqueado,
  output logic [1:0] tentativas,
  output logic       erro,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G
);

  localparam int unsigned SENHA_W = DIGITO_W * N_DIGITOS;
  localparam int unsigned IDX_W   = (N_DIGITOS > 1) ? $clog2(N_DIGITOS + 1) : 1;
  localparam int unsigned TIMER_W = (CICLOS_BLOQUEIO > 1) ? $clog2(CICLOS_BLOQUEIO + 1) : 1;

  estado_t              estado, estado_n;
  logic                 insere_q;
  logic [IDX_W-1:0]     idx, idx_n;
  logic                 falha, falha_n;
  logic [1:0]           tent_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [SENHA_W-1:0]   senha, senha_n;
  logic [SENHA_W-1:0]   sombra, sombra_n;
  logic [DIGITO_W-1:0]  digito, digito_n;
  logic                 mostra, mostra_n;
  logic                 erro_n;
  logic                 falha_acc;
  logic [SENHA_W-1:0]   sombra_acc;
  logic [SEG_W-1:0]     seg, seg_c;

  logic                 aceita;
  logic                 valido;
  logic                 invalido;
  logic                 ultimo;
  logic [DIGITO_W-1:0]  digito_senha;

  assign aceita       = insere & ~insere_q;
  assign invalido     = aceita & (numero > 4'd9);
  assign valido       = aceita & ~(numero > 4'd9);
  assign ultimo       = (idx == IDX_W'(N_DIGITOS - 1));
  // Password digit idx, first digit held in the most significant nibble
  assign digito_senha = DIGITO_W'(senha >> (DIGITO_W * (N_DIGITOS - 1 - 32'(idx))));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_n;
  end

  // Next-state and datapath update decisions
  always_comb begin
    estado_n   = estado;
    idx_n      = idx;
    falha_n    = falha;
    tent_n     = tentativas;
    timer_n    = timer;
    senha_n    = senha;
    sombra_n   = sombra;
    digito_n   = digito;
    mostra_n   = mostra;
    erro_n     = 1'b0;
    falha_acc  = 1'b0;
    sombra_acc = (sombra << DIGITO_W) | SENHA_W'(numero);

    if (estado == BLOQUEADO) begin
      // Strobes are ignored for the whole lockout, expiry cycle included
      if (timer == '0) begin
        estado_n = OCIOSO;
        tent_n   = 2'd0;
      end else begin
        timer_n = timer - TIMER_W'(1);
      end
    end else if (invalido) begin
      erro_n = 1'b1;
      if (estado == PROGRAMA) begin
        estado_n = OCIOSO;
        idx_n    = '0;
      end
    end else if (valido) begin
      digito_n = numero;
      mostra_n = 1'b1;
      case (estado)
        OCIOSO, ENTRADA: begin
          falha_acc = ((estado == ENTRADA) & falha) | (numero != digito_senha);
          if (ultimo) begin
            idx_n   = '0;
            falha_n = 1'b0;
            if (!falha_acc) begin
              estado_n = ABERTO;
              tent_n   = 2'd0;
            end else begin
              if (tentativas < 2'(MAX_TENTATIVAS)) tent_n = tentativas + 2'd1;
              if (tent_n >= 2'(MAX_TENTATIVAS)) begin
                estado_n = BLOQUEADO;
                timer_n  = TIMER_W'(CICLOS_BLOQUEIO - 1);
              end else begin
                estado_n = OCIOSO;
              end
            end
          end else begin
            estado_n = ENTRADA;
            idx_n    = idx + IDX_W'(1);
            falha_n  = falha_acc;
          end
        end
        ABERTO: begin
          estado_n = modo ? PROGRAMA : OCIOSO;
          idx_n    = '0;
          falha_n  = 1'b0;
          sombra_n = '0;
        end
        PROGRAMA: begin
          if (ultimo) begin
            senha_n  = sombra_acc;
            estado_n = OCIOSO;
            idx_n    = '0;
          end else begin
            sombra_n = sombra_acc;
            idx_n    = idx + IDX_W'(1);
          end
        end
        default: begin
          estado_n = OCIOSO;
          idx_n    = '0;
          falha_n  = 1'b0;
        end
      endcase
    end
  end

  // Display pattern for the upcoming cycle
  decodificador_7seg u_dec (
    .digito (digito_n),
    .apaga  (~mostra_n),
    .traco  (estado_n == BLOQUEADO),
    .seg_c  (seg_c)
  );

  // Datapath registers and registered Moore outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      insere_q   <= 1'b0;
      idx        <= '0;
      falha      <= 1'b0;
      tentativas <= 2'd0;
      timer      <= '0;
      senha      <= SENHA_PADRAO;
      sombra     <= '0;
      digito     <= '0;
      mostra     <= 1'b0;
      LED        <= 1'b0;
      bloqueado  <= 1'b0;
      erro       <= 1'b0;
      seg        <= SEG_BLANK;
    end else begin
      insere_q   <= insere;
      idx        <= idx_n;
      falha      <= falha_n;
      tentativas <= tent_n;
      timer      <= timer_n;
      senha      <= senha_n;
      sombra     <= sombra_n;
      digito     <= digito_n;
      mostra     <= mostra_n;
      LED        <= (estado_n == ABERTO) || (estado_n == PROGRAMA);
      bloqueado  <= (estado_n == BLOQUEADO);
      erro       <= erro_n;
      seg        <= seg_c;
    end
  end

  assign {A, B, C, D, E, F, G} = seg;

endmodule

// File: tb/tb_controlador_cofre.sv
// Directed bench for controlador_cofre with a per-cycle behavioural model.
module tb_controlador_cofre;

  localparam int N   = 6;
  localparam int MAX = 3;
  localparam int CIC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       insere;
  logic [4:1] numero;
  logic       modo;
  logic       LED, bloqueado, erro;
  logic [1:0] tentativas;
  logic       A, B, C, D, E, F, G;

  int checks = 0;
  int erros  = 0;
  bit ativo  = 1'b0;

  controlador_cofre #(
    .N_DIGITOS(N), .MAX_TENTATIVAS(MAX), .CICLOS_BLOQUEIO(CIC),
    .SENHA_PADRAO(24'h590281)
  ) dut (
    .clk(clk), .reset(reset), .insere(insere), .numero(numero), .modo(modo),
    .LED(LED), .bloqueado(bloqueado), .tentativas(tentativas), .erro(erro),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G)
  );

  always #5 clk = ~clk;

  // Behavioural model: abstract flags, digit queues and a lockout countdown
  logic [6:0] tabela [10];
  int  senha_m [N];
  int  digitada [$];
  int  sombra_m [$];
  bit  aberto_m, prog_m, ins_q_m, erro_m;
  int  resta_bloq, tent_m, ultimo_m;

  initial begin
    tabela[0] = 7'b1111110; tabela[1] = 7'b0110000; tabela[2] = 7'b1101101;
    tabela[3] = 7'b1111001; tabela[4] = 7'b0110011; tabela[5] = 7'b1011011;
    tabela[6] = 7'b1011111; tabela[7] = 7'b1110000; tabela[8] = 7'b1111111;
    tabela[9] = 7'b1111011;
  end

  function automatic logic [6:0] seg_esperado();
    if (resta_bloq > 0) return 7'b0000001;
    if (ultimo_m < 0)   return 7'b0000000;
    return tabela[ultimo_m];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      senha_m = '{5, 9, 0, 2, 8, 1};
      digitada.delete(); sombra_m.delete();
      aberto_m = 0; prog_m = 0; ins_q_m = 0; erro_m = 0;
      resta_bloq = 0; tent_m = 0; ultimo_m = -1;
    end else begin
      bit strobe;
      bit ok;
      strobe  = insere && !ins_q_m;
      ins_q_m = insere;
      erro_m  = 0;
      if (resta_bloq > 0) begin
        resta_bloq--;
        if (resta_bloq == 0) tent_m = 0;
      end else if (strobe && int'(numero) > 9) begin
        erro_m = 1;
        if (prog_m) begin prog_m = 0; sombra_m.delete(); end
      end else if (strobe) begin
        ultimo_m = int'(numero);
        if (aberto_m) begin
          aberto_m = 0;
          prog_m   = modo;
          sombra_m.delete();
        end else if (prog_m) begin
          sombra_m.push_back(int'(numero));
          if (sombra_m.size() == N) begin
            for (int i = 0; i < N; i++) senha_m[i] = sombra_m[i];
            sombra_m.delete();
            prog_m = 0;
          end
        end else begin
          digitada.push_back(int'(numero));
          if (digitada.size() == N) begin
            ok = 1;
            for (int i = 0; i < N; i++) if (digitada[i] != senha_m[i]) ok = 0;
            digitada.delete();
            if (ok) begin
              aberto_m = 1; tent_m = 0;
            end else begin
              tent_m++;
              if (tent_m >= MAX) resta_bloq = CIC;
            end
          end
        end
      end
    end
  end

  task automatic check(input string nome, input int got, input int exp);
    checks++;
    if (got != exp) begin
      erros++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (ativo) begin
      check("model LED",        int'(LED),        int'(aberto_m || prog_m));
      check("model bloqueado",  int'(bloqueado),  int'(resta_bloq > 0));
      check("model tentativas", int'(tentativas), tent_m);
      check("model erro",       int'(erro),       int'(erro_m));
      check("model segments",   int'({A, B, C, D, E, F, G}), int'(seg_esperado()));
    end
  end

  task automatic pulso(input int d, input bit m);
    @(posedge clk); #2;
    numero = 4'(d); modo = m; insere = 1'b1;
    @(posedge clk); #2;
    insere = 1'b0; modo = 1'b0;
  endtask

  task automatic senha6(input int d0, d1, d2, d3, d4, d5);
    pulso(d0, 0); pulso(d1, 0); pulso(d2, 0);
    pulso(d3, 0); pulso(d4, 0); pulso(d5, 0);
  endtask

  task automatic espera(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; insere = 1'b0; numero = 4'd0; modo = 1'b0;
    espera(3);
    check("reset LED", int'(LED), 0);
    check("reset segments", int'({A, B, C, D, E, F, G}), 0);
    reset = 1'b1;
    ativo = 1'b1;

    // 1: default password opens
    senha6(5, 9, 0, 2, 8, 1);
    check("t1 LED", int'(LED), 1);
    check("t1 tentativas", int'(tentativas), 0);
    check("t1 segments show 1", int'({A, B, C, D, E, F, G}), 7'b0110000);
    pulso(3, 0);
    check("t1 relock", int'(LED), 0);

    // 2: three wrong attempts, lockout, ignored digit, expiry
    senha6(5, 9, 0, 2, 8, 2);
    check("t2 tentativas 1", int'(tentativas), 1);
    senha6(5, 9, 0, 2, 8, 2);
    check("t2 tentativas 2", int'(tentativas), 2);
    senha6(5, 9, 0, 2, 8, 2);
    check("t2 bloqueado", int'(bloqueado), 1);
    check("t2 dash", int'({A, B, C, D, E, F, G}), 7'b0000001);
    pulso(12, 0);
    check("t2 no erro in lockout", int'(erro), 0);
    espera(5);
    check("t2 still locked", int'(bloqueado), 1);
    espera(1);
    check("t2 unlocked", int'(bloqueado), 0);
    check("t2 tentativas cleared", int'(tentativas), 0);

    // 3: held strobe counts once, invalid digit not counted
    @(posedge clk); #2;
    numero = 4'd5; insere = 1'b1;
    espera(4);
    insere = 1'b0;
    pulso(12, 0);
    check("t3 erro pulse", int'(erro), 1);
    check("t3 display kept", int'({A, B, C, D, E, F, G}), 7'b1011011);
    espera(1);
    check("t3 erro cleared", int'(erro), 0);
    pulso(9, 0); pulso(0, 0); pulso(2, 0); pulso(8, 0); pulso(1, 0);
    check("t3 opens", int'(LED), 1);

    // 4: reprogram to 123456
    pulso(7, 1);
    check("t4 programa LED", int'(LED), 1);
    senha6(1, 2, 3, 4, 5, 6);
    check("t4 back to idle", int'(LED), 0);
    senha6(5, 9, 0, 2, 8, 1);
    check("t4 old fails", int'(tentativas), 1);
    senha6(1, 2, 3, 4, 5, 6);
    check("t4 new opens", int'(LED), 1);

    // Invalid digit aborts programming, password unchanged
    pulso(0, 1);
    pulso(9, 0); pulso(9, 0); pulso(15, 0);
    check("abort erro", int'(erro), 1);
    check("abort LED", int'(LED), 0);
    senha6(1, 2, 3, 4, 5, 6);
    check("abort kept password", int'(LED), 1);
    pulso(0, 0);

    // 5: reset mid-entry restores default password
    pulso(1, 0); pulso(2, 0); pulso(3, 0);
    reset = 1'b0;
    #1;
    check("t5 LED", int'(LED), 0);
    check("t5 tentativas", int'(tentativas), 0);
    check("t5 segments", int'({A, B, C, D, E, F, G}), 0);
    espera(2);
    reset = 1'b1;
    senha6(5, 9, 0, 2, 8, 1);
    check("t5 default opens", int'(LED), 1);

    // 6: relock digit does not count toward next entry
    pulso(5, 0);
    check("t6 relock", int'(LED), 0);
    senha6(5, 9, 0, 2, 8, 1);
    check("t6 reopens", int'(LED), 1);

    espera(3);
    ativo = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, erros);
    $finish;
  end

endmodule
